fetch_sequencer: RTL

Fetch-stage PC sequencer for the 5-stage MIPS pipeline. Owns the PC register and drives the next fetch address from sequential increment and D-stage branch/jump redirects. Coordinates redirects with hazard stalls and instruction-memory wait states, and flushes the wrong-path F/D slot. Also handles misaligned-target faults and halt.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_pc_reg.sv | 23 ++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FAULT = 2'd2,
        HALT  = 2'd3
    } fseq_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// 32-bit program counter register with asynchronous reset and load enable.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // PC storage: reset to the boot address, otherwise load on enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: increment, D-stage redirects, imem waits, faults, halt.
// Build option: define DELAY_SLOT_EN to keep the F-stage word as a branch delay slot.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        imemReadyF,
    input  logic        redirectD,
    input  logic [31:0] redirectAddrD,
    input  logic        haltD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        validF,
    output logic        flushD,
    output logic        exceptionF,
    output logic [31:0] faultAddr,
    output logic        halted
);

`ifdef DELAY_SLOT_EN
    localparam logic REDIRECT_FLUSH = 1'b0;
    localparam logic PEND_KEEP_WORD = 1'b1;
`else
    localparam logic REDIRECT_FLUSH = 1'b1;
    localparam logic PEND_KEEP_WORD = 1'b0;
`endif

    fseq_state_e state_r;
    fseq_state_e next_state_s;
    logic [31:0] pend_addr_r;
    logic [31:0] fault_addr_r;
    logic        halted_r;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic        pc_load_s;
    logic        pend_load_s;
    logic        fault_load_s;
    logic        flush_s;
    logic        exc_s;
    logic        valid_s;
    logic        accept_s;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load_s),
        .d     (pc_next_s),
        .q     (pc_s)
    );

    assign accept_s = (state_r == RUN) && !stallD;

    // Next-state, next-PC and per-cycle strobes.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_s + 32'd4;
        pc_load_s    = 1'b0;
        pend_load_s  = 1'b0;
        fault_load_s = 1'b0;
        flush_s      = 1'b0;
        exc_s        = 1'b0;
        valid_s      = 1'b0;
        case (state_r)
            RUN: begin
                valid_s = imemReadyF & ~stallF;
                if (accept_s && haltD) begin
                    flush_s      = 1'b1;
                    next_state_s = HALT;
                end else if (accept_s && redirectD && is_misaligned(redirectAddrD)) begin
                    // Faults always squash the wrong-path word, delay slot or not.
                    pc_next_s    = EXC_VECTOR;
                    pc_load_s    = 1'b1;
                    fault_load_s = 1'b1;
                    flush_s      = 1'b1;
                    next_state_s = FAULT;
                end else if (accept_s && redirectD) begin
                    flush_s = REDIRECT_FLUSH;
                    if (imemReadyF) begin
                        pc_next_s = redirectAddrD;
                        pc_load_s = 1'b1;
                    end else begin
                        pend_load_s  = 1'b1;
                        next_state_s = PEND;
                    end
                end else if (imemReadyF && !stallF) begin
                    pc_load_s = 1'b1;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            PEND: begin
                // PCF holds the old address until imem drains the outstanding fetch.
                valid_s = PEND_KEEP_WORD & imemReadyF;
                if (imemReadyF) begin
                    pc_next_s    = pend_addr_r;
                    pc_load_s    = 1'b1;
                    next_state_s = RUN;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            FAULT: begin
                exc_s        = 1'b1;
                next_state_s = RUN;
            end
            HALT: begin
                next_state_s = HALT;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Sequencer state and side registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= RUN;
            pend_addr_r  <= 32'h0000_0000;
            fault_addr_r <= 32'h0000_0000;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            pend_addr_r  <= pend_load_s  ? redirectAddrD : pend_addr_r;
            fault_addr_r <= fault_load_s ? redirectAddrD : fault_addr_r;
            halted_r     <= (next_state_s == HALT);
        end
    end

    // Strobes are forced low while reset is held so reset values are visible at once.
    assign validF     = valid_s & ~reset;
    assign flushD     = flush_s & ~reset;
    assign exceptionF = exc_s & ~reset;
    assign PCF        = pc_s;
    assign PCPlus4F   = pc_s + 32'd4;
    assign faultAddr  = fault_addr_r;
    assign halted     = halted_r;

endmodule
